// File: rtl/ysyx_25060170_ifu_pkg.sv
// ysyx_25060170_ifu_pkg: shared widths, reset fetch address and FSM encoding
// for the instruction fetch unit.
`default_nettype none

package ysyx_25060170_ifu_pkg;

    localparam int YSYX_25060170_PC_W   = 32;
    localparam int YSYX_25060170_INST_W = 32;

    localparam logic [YSYX_25060170_PC_W-1:0] YSYX_25060170_RESET_PC = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DROP = 3'd3,
        S_HOLD = 3'd4
    } ifu_state_t;

endpackage

`default_nettype wire

// File: rtl/ysyx_25060170_ifu.sv
// ysyx_25060170_ifu: single-outstanding instruction fetch unit with
// redirect handling and an IF/ID valid/ready output stage.
`default_nettype none

module ysyx_25060170_ifu
    import ysyx_25060170_ifu_pkg::*;
#(
    parameter logic [YSYX_25060170_PC_W-1:0] RESET_PC = YSYX_25060170_RESET_PC
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic                            imem_req_valid,
    output logic [YSYX_25060170_PC_W-1:0]   imem_req_addr,
    input  logic                            imem_req_ready,
    input  logic                            imem_rsp_valid,
    input  logic [YSYX_25060170_INST_W-1:0] imem_rsp_data,
    input  logic                            redirect_valid,
    input  logic [YSYX_25060170_PC_W-1:0]   redirect_pc,
    input  logic                            id_ready,
    output logic                            if_valid,
    output logic [YSYX_25060170_INST_W-1:0] if_inst,
    output logic [YSYX_25060170_PC_W-1:0]   if_pc
);

    ifu_state_t                      state;
    ifu_state_t                      state_nxt;
    logic                            idle_seen;
    logic                            capture;
    logic                            release_out;
    logic [YSYX_25060170_PC_W-1:0]   pc;
    logic [YSYX_25060170_PC_W-1:0]   redirect_target;
    logic                            unused_redirect_lsbs;

    // Instructions are word aligned, so the low redirect bits carry no meaning.
    assign redirect_target      = {redirect_pc[YSYX_25060170_PC_W-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        capture        = 1'b0;
        release_out    = 1'b0;
        imem_req_valid = 1'b0;
        imem_req_addr  = pc;
        case (state)
            S_IDLE: begin
                if (idle_seen) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                imem_req_valid = 1'b1;
                // An accepted request that is redirected in the same cycle
                // still owes us a response, which must be discarded.
                if (imem_req_ready) begin
                    state_nxt = redirect_valid ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
                end else if (imem_rsp_valid) begin
                    capture   = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) begin
                    state_nxt = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect_valid || id_ready) begin
                    release_out = 1'b1;
                    state_nxt   = S_REQ;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_seen <= 1'b0;
            pc        <= RESET_PC;
            if_valid  <= 1'b0;
            if_inst   <= '0;
            if_pc     <= '0;
        end else begin
            // Holds IDLE for one full cycle after reset release.
            idle_seen <= (state == S_IDLE);

            if (redirect_valid) begin
                pc <= redirect_target;
            end else if (capture) begin
                pc <= pc + 32'd4;
            end

            if (capture) begin
                if_valid <= 1'b1;
                if_inst  <= imem_rsp_data;
                if_pc    <= pc;
            end else if (release_out) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
